// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths: state encoding,
// line levels and the default word width.
package uart_pkg;
    localparam int   DEFAULT_DATA_W = 32;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
endpackage

// File: rtl/tx_piso.sv
// Parallel-in serial-out register: loads a word, shifts right, presents bit 0.
// This is the mirror of the receiver's SIPO.
module tx_piso #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] word,
    output logic              lsb
);
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        shreg <= '0;
        else if (load)  shreg <= word;
        else if (shift) shreg <= {1'b0, shreg[DATA_W-1:1]};
    end

    assign lsb = shreg[0];
endmodule

// File: rtl/uart_transmitter.sv
// UART frame serialiser: start, DATA_W bits LSB-first, parity, stop, one bit per
// Baud_Clk. All outputs are registered.
import uart_pkg::*;

module uart_transmitter #(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              Baud_Clk,
    input  logic              Reset,
    input  logic              Tx_Start,
    input  logic [DATA_W-1:0] Tx_DataIn,
    output logic              Tx_Out,
    output logic              Tx_Busy,
    output logic              Tx_Done
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_bit;
    logic             piso_lsb;
    logic             accept;
    logic             shift;

    assign accept = Tx_Start && (state == IDLE || state == STOP);
    assign shift  = (state == START) || (state == DATA && bit_cnt != LAST_BIT);

    tx_piso #(.DATA_W(DATA_W)) u_piso (
        .clk   (Baud_Clk),
        .rst   (Reset),
        .load  (accept),
        .shift (shift),
        .word  (Tx_DataIn),
        .lsb   (piso_lsb)
    );

    // Parity accumulates over the bits actually shifted out of the latched
    // copy, so live Tx_DataIn can never disturb it.
    always_ff @(posedge Baud_Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            Tx_Out  <= STOP_BIT;
            Tx_Busy <= 1'b0;
            Tx_Done <= 1'b0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        state   <= START;
                        Tx_Out  <= START_BIT;
                        Tx_Busy <= 1'b1;
                        par_bit <= PARITY_ODD;
                    end else begin
                        state   <= IDLE;
                        Tx_Out  <= STOP_BIT;
                        Tx_Busy <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    Tx_Out  <= piso_lsb;
                    par_bit <= par_bit ^ piso_lsb;
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        state  <= PARITY;
                        Tx_Out <= par_bit;
                    end else begin
                        Tx_Out  <= piso_lsb;
                        par_bit <= par_bit ^ piso_lsb;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    Tx_Out  <= STOP_BIT;
                    Tx_Done <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    Tx_Out  <= STOP_BIT;
                    Tx_Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes the
// serial output and compares each completed frame against the queue.
module tb_uart_transmitter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         start1 = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] data1 = '0;
    logic         tx, busy, done, tx1, busy1, done1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = -1000;

    typedef struct {
        logic [W-1:0] word;
        logic         par;
        int           acc;
        bit           b2b;
    } exp_t;
    exp_t exp_q[$];

    uart_transmitter #(.DATA_W(W), .PARITY_ODD(1'b0)) dut (
        .Baud_Clk (clk), .Reset (rst), .Tx_Start (start), .Tx_DataIn (data),
        .Tx_Out (tx), .Tx_Busy (busy), .Tx_Done (done)
    );

    uart_transmitter #(.DATA_W(W), .PARITY_ODD(1'b1)) dut_odd (
        .Baud_Clk (clk), .Reset (rst), .Tx_Start (start1), .Tx_DataIn (data1),
        .Tx_Out (tx1), .Tx_Busy (busy1), .Tx_Done (done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_rst(input string name);
        check1({name, "_tx"}, tx, 1'b1);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_done"}, done, 1'b0);
        check1({name, "_odd_tx"}, tx1, 1'b1);
        check1({name, "_odd_busy"}, busy1, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] w, input logic p, input bit b2b);
        @(negedge clk);
        start = 1'b1;
        data  = w;
        @(posedge clk);
        #1;
        exp_q.push_back('{w, p, cyc, b2b});
        start = 1'b0;
        data  = ~w;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 100);
        check1("idle_reached", busy, 1'b0);
    endtask

    // Line monitor: pos 1..W data bits, W+1 parity, W+2 stop.
    initial begin : monitor
        int           pos;
        int           start_cyc;
        logic [W-1:0] w;
        logic         p;
        logic         mid_ok;
        exp_t         e;
        pos = -1;
        start_cyc = 0;
        w = '0;
        p = 1'b0;
        mid_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = -1;
            end else if (pos < 0) begin
                if (tx === 1'b0) begin
                    check1("start_busy", busy, 1'b1);
                    start_cyc = cyc;
                    mid_ok = 1'b1;
                    pos = 1;
                end else begin
                    check1("idle_busy", busy, 1'b0);
                    check1("idle_done", done, 1'b0);
                end
            end else if (pos <= W + 1) begin
                if (pos <= W) w[pos-1] = tx;
                else          p = tx;
                if (busy !== 1'b1 || done !== 1'b0) mid_ok = 1'b0;
                pos++;
            end else begin
                check1("stop_bit", tx, 1'b1);
                check1("done_pulse", done, 1'b1);
                check1("frame_busy_done_mid", mid_ok, 1'b1);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame: got word %h with none expected", w);
                end else begin
                    e = exp_q.pop_front();
                    checkw("frame_data", w, e.word);
                    check1("frame_parity", p, e.par);
                    checkw("start_latency", 32'(start_cyc - e.acc), 32'd0);
                    checkw("done_cycle", 32'(cyc - e.acc), 32'd34);
                    if (e.b2b) checkw("done_spacing", 32'(cyc - last_done), 32'd35);
                end
                last_done = cyc;
                pos = -1;
            end
        end
    end

    initial begin : stim
        logic [W-1:0] w;
        // Reset from power-up
        #2 rst = 1'b1;
        #1 chk_rst("reset_init");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Reset pulse while idle
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_rst("reset_idle");
        @(posedge clk);
        #3 rst = 1'b0;

        // Mid-frame reset: frame abandoned, never queued
        @(negedge clk);
        start = 1'b1;
        data  = 32'hCAFE_F00D;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_rst("reset_midframe");
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic frame: 16 ones -> even parity 0
        send(32'hA5A5_0F0F, 1'b0, 1'b0);
        wait_idle();

        // Single one: even parity 1 on dut, odd parity 0 on dut_odd
        @(negedge clk);
        start = 1'b1; start1 = 1'b1;
        data  = 32'h0000_0001; data1 = 32'h0000_0001;
        @(posedge clk);
        #1;
        exp_q.push_back('{32'h0000_0001, 1'b1, cyc, 1'b0});
        start = 1'b0; start1 = 1'b0;
        repeat (34) @(negedge clk);
        check1("odd_parity_bit", tx1, 1'b0);
        @(negedge clk);
        check1("odd_stop_done", done1, 1'b1);
        wait_idle();

        // Back-to-back: next word offered during STOP
        send(32'h0F0F_00FF, 1'b0, 1'b0);
        repeat (35) @(negedge clk);
        start = 1'b1;
        data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        exp_q.push_back('{32'hFFFF_FFFF, 1'b0, cyc, 1'b1});
        start = 1'b0;
        check1("b2b_busy_held", busy, 1'b1);
        wait_idle();

        // Start pulse and data change mid-frame are ignored
        send(32'h1234_5678, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        data  = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        data  = 32'h0000_0000;
        wait_idle();
        repeat (2) @(negedge clk);
        check1("ignored_start_idle", tx, 1'b1);

        // Random words, decoded by the monitor as a receiver would
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            send(w, ^w, 1'b0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        checkw("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
